backward_maccum: RTL and testbench

//  Backward-pass multiply-accumulate: consumes NC error deltas from the next layer

---
 rtl/backward_maccum.sv | 172 +++++++++++++++++
 tb/tb_backward_maccum.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/backward_maccum.sv
// backward_maccum: backward-pass multiply-accumulate, dp[p] = sum_c w[p][c]*d[c].
// Weight matrix and delta vector are joined from two independent valid/ready
// channels. NP parallel multipliers process one delta column per cycle.
// The result is held on a valid/ready output until it is accepted.
module backward_maccum #(
    parameter int unsigned NP    = 3,
    parameter int unsigned NC    = 2,
    parameter int unsigned WV    = 8,
    parameter int unsigned WF    = 0,
    parameter string       BURST = "yes",
    localparam int unsigned WO   = $clog2(NC) + WV
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iValid_AM_Weight,
    output logic                  oReady_AM_Weight,
    input  logic [NP*NC*WV-1:0]   iData_AM_Weight,
    input  logic                  iValid_AM_Delta,
    output logic                  oReady_AM_Delta,
    input  logic [NC*WV-1:0]      iData_AM_Delta,
    output logic                  oValid_BM_Delta,
    input  logic                  iReady_BM_Delta,
    output logic [NP*WO-1:0]      oData_BM_Delta
);

    localparam int unsigned CW      = (NC > 1) ? $clog2(NC) : 1;
    localparam bit          BurstEn = (BURST == "yes");

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } stateT;

    stateT                 state;
    stateT                 stateNext;
    logic                  fullW;
    logic                  fullD;
    logic                  fullWNext;
    logic                  fullDNext;
    logic                  readyWNext;
    logic                  readyDNext;
    logic                  capW;
    logic                  capD;
    logic                  enterAccum;
    logic                  lastCol;
    logic                  outFire;
    logic [CW-1:0]         count;
    logic [NP*NC*WV-1:0]   weightQ;
    logic [NC*WV-1:0]      deltaQ;
    logic [WO-1:0]         acc      [NP];
    logic [WO-1:0]         accSum   [NP];
    logic signed [WV-1:0]  wSel     [NP];
    logic signed [WV-1:0]  dSel;
    logic signed [2*WV-1:0] prodFull [NP];
    logic signed [2*WV-1:0] prodShift[NP];
    logic signed [WV-1:0]  prodTrunc[NP];

    assign capW = iValid_AM_Weight && oReady_AM_Weight;
    assign capD = iValid_AM_Delta  && oReady_AM_Delta;

    // State register, operand flags and registered readies
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state            <= IDLE;
            fullW            <= 1'b0;
            fullD            <= 1'b0;
            oReady_AM_Weight <= 1'b1;
            oReady_AM_Delta  <= 1'b1;
        end else begin
            state            <= stateNext;
            fullW            <= fullWNext;
            fullD            <= fullDNext;
            oReady_AM_Weight <= readyWNext;
            oReady_AM_Delta  <= readyDNext;
        end
    end

    // Next-state, flag update and ready look-ahead
    always_comb begin
        stateNext  = state;
        fullWNext  = fullW;
        fullDNext  = fullD;
        enterAccum = 1'b0;
        lastCol    = 1'b0;
        outFire    = 1'b0;
        if (capW) fullWNext = 1'b1;
        if (capD) fullDNext = 1'b1;
        case (state)
            IDLE: begin
                if (fullW && fullD) begin
                    stateNext  = ACCUM;
                    enterAccum = 1'b1;
                end
            end
            ACCUM: begin
                if (count == CW'(NC - 1)) begin
                    lastCol   = 1'b1;
                    fullWNext = 1'b0;
                    fullDNext = 1'b0;
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (oValid_BM_Delta && iReady_BM_Delta) begin
                    outFire = 1'b1;
                    // Operands captured while waiting start the next pass directly
                    if (BurstEn && fullW && fullD) begin
                        stateNext  = ACCUM;
                        enterAccum = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
        readyWNext = !fullWNext && ((stateNext == IDLE) || (BurstEn && (stateNext == DONE)));
        readyDNext = !fullDNext && ((stateNext == IDLE) || (BurstEn && (stateNext == DONE)));
    end

    // Operand capture registers
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            weightQ <= '0;
            deltaQ  <= '0;
        end else begin
            if (capW) weightQ <= iData_AM_Weight;
            if (capD) deltaQ  <= iData_AM_Delta;
        end
    end

    // Column select, wrapped product and accumulator sum for the current column
    always_comb begin
        dSel = deltaQ[int'(count)*WV +: WV];
        for (int p = 0; p < NP; p++) begin
            wSel[p]      = weightQ[(p*NC + int'(count))*WV +: WV];
            prodFull[p]  = wSel[p] * dSel;
            prodShift[p] = prodFull[p] >>> WF;
            prodTrunc[p] = prodShift[p][WV-1:0];
            accSum[p]    = acc[p] + WO'(prodTrunc[p]);
        end
    end

    // Column counter and accumulators, cleared on ACCUM entry
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            count <= '0;
            for (int p = 0; p < NP; p++) acc[p] <= '0;
        end else if (enterAccum) begin
            count <= '0;
            for (int p = 0; p < NP; p++) acc[p] <= '0;
        end else if (state == ACCUM) begin
            count <= count + CW'(1);
            for (int p = 0; p < NP; p++) acc[p] <= accSum[p];
        end
    end

    // Result register and output valid; data only changes on the final column
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oValid_BM_Delta <= 1'b0;
            oData_BM_Delta  <= '0;
        end else if (lastCol) begin
            oValid_BM_Delta <= 1'b1;
            for (int p = 0; p < NP; p++) oData_BM_Delta[p*WO +: WO] <= accSum[p];
        end else if (outFire) begin
            oValid_BM_Delta <= 1'b0;
        end
    end

endmodule

// File: tb/tb_backward_maccum.sv
// Bench for backward_maccum (NP=3, NC=2, WV=8, WF=0): table vectors plus
// join-order, back-pressure/burst, mid-pass reset and non-burst sequences.
module tb_backward_maccum;

    localparam int unsigned WWB = 48;
    localparam int unsigned DWB = 16;
    localparam int unsigned OWB = 27;

    logic           clk = 1'b0;
    logic           rst;
    logic           vW, rW, vD, rD, vO, iR;
    logic [WWB-1:0] dW;
    logic [DWB-1:0] dD;
    logic [OWB-1:0] oD;

    logic           vW2, rW2, vD2, rD2, vO2, iR2;
    logic [WWB-1:0] dW2;
    logic [DWB-1:0] dD2;
    logic [OWB-1:0] oD2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    backward_maccum dut (
        .iCLK(clk), .iRST(rst),
        .iValid_AM_Weight(vW), .oReady_AM_Weight(rW), .iData_AM_Weight(dW),
        .iValid_AM_Delta(vD), .oReady_AM_Delta(rD), .iData_AM_Delta(dD),
        .oValid_BM_Delta(vO), .iReady_BM_Delta(iR), .oData_BM_Delta(oD)
    );

    backward_maccum #(.BURST("no")) dutNb (
        .iCLK(clk), .iRST(rst),
        .iValid_AM_Weight(vW2), .oReady_AM_Weight(rW2), .iData_AM_Weight(dW2),
        .iValid_AM_Delta(vD2), .oReady_AM_Delta(rD2), .iData_AM_Delta(dD2),
        .oValid_BM_Delta(vO2), .iReady_BM_Delta(iR2), .oData_BM_Delta(oD2)
    );

    typedef struct {
        logic [WWB-1:0] w;
        logic [DWB-1:0] d;
        logic [OWB-1:0] e;
    } vecT;

    vecT vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present operands at a negedge, wait for the needed readies, capture on the next posedge
    task automatic sendOps(input logic doW, input logic doD,
                           input logic [WWB-1:0] w, input logic [DWB-1:0] d);
        int guard;
        @(negedge clk);
        vW = doW; dW = w; vD = doD; dD = d;
        guard = 0;
        while (((doW && !rW) || (doD && !rD)) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("capture_ready", 32'(guard < 50), 32'd1);
        @(posedge clk); #1;
        vW = 1'b0; vD = 1'b0;
    endtask

    // Count edges until oValid rises (called #1 after an edge)
    task automatic waitValid(input int expLat, input string name);
        int k;
        k = 0;
        while (!vO && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk({name, "_latency"}, 32'(k), 32'(expLat));
    endtask

    task automatic drain(input string name);
        @(negedge clk);
        iR = 1'b1;
        @(posedge clk); #1;
        iR = 1'b0;
        chk({name, "_valid_drop"}, 32'(vO), 32'd0);
    endtask

    task automatic runVec(input int i);
        sendOps(1'b1, 1'b1, vecs[i].w, vecs[i].d);
        waitValid(3, $sformatf("vec%0d", i));
        chk($sformatf("vec%0d_data", i), 32'(oD), 32'(vecs[i].e));
        drain($sformatf("vec%0d", i));
    endtask

    initial begin
        int k;
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // w packed {w21,w20,w11,w10,w01,w00}; d packed {d1,d0}; e packed {dp2,dp1,dp0}
        vecs[0] = '{w: {8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}, d: {8'd1, 8'd2},
                    e: {9'd13, 9'd7, 9'd1}};
        vecs[1] = '{w: {8'h03, 8'hFC, 8'hFF, 8'h02, 8'h01, 8'h01}, d: {8'h02, 8'hFD},
                    e: {9'h012, 9'h1F8, 9'h1FF}};
        vecs[2] = '{w: {40'h0, 8'h7F}, d: {8'h00, 8'h02},
                    e: {9'h000, 9'h000, 9'h1FE}};
        vecs[3] = '{w: {6{8'h80}}, d: {8'h01, 8'h01},
                    e: {9'h100, 9'h100, 9'h100}};
        vecs[4] = '{w: {6{8'h01}}, d: {8'h7F, 8'h7F},
                    e: {9'h0FE, 9'h0FE, 9'h0FE}};

        rst = 1'b1;
        vW = 0; vD = 0; iR = 0; dW = '0; dD = '0;
        vW2 = 0; vD2 = 0; iR2 = 0; dW2 = '0; dD2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 32'(vO), 32'd0);
        chk("reset_data", 32'(oD), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready_w", 32'(rW), 32'd1);
        chk("reset_ready_d", 32'(rD), 32'd1);

        // Table vectors, both operands in the same cycle
        for (int i = 0; i < 5; i++) runVec(i);

        // Join order: delta first, weights 5 cycles later
        sendOps(1'b0, 1'b1, '0, vecs[0].d);
        k = 0;
        repeat (5) begin
            @(negedge clk);
            if (rD !== 1'b0 || vO !== 1'b0 || rW !== 1'b1) k++;
        end
        chk("join_wait_state", 32'(k), 32'd0);
        sendOps(1'b1, 1'b0, vecs[0].w, '0);
        waitValid(3, "join");
        chk("join_data", 32'(oD), 32'(vecs[0].e));
        drain("join");

        // Back-pressure with burst capture in DONE
        sendOps(1'b1, 1'b1, vecs[0].w, vecs[0].d);
        waitValid(3, "bp");
        k = 0;
        repeat (10) begin
            @(negedge clk);
            if (vO !== 1'b1 || oD !== vecs[0].e) k++;
        end
        chk("bp_hold", 32'(k), 32'd0);
        chk("bp_ready_w_done", 32'(rW), 32'd1);
        chk("bp_ready_d_done", 32'(rD), 32'd1);
        sendOps(1'b1, 1'b1, vecs[1].w, vecs[1].d);
        @(negedge clk);
        chk("bp_ready_w_full", 32'(rW), 32'd0);
        chk("bp_ready_d_full", 32'(rD), 32'd0);
        chk("bp_data_stable", 32'(oD), 32'(vecs[0].e));
        drain("bp_first");
        waitValid(2, "bp_burst");
        chk("bp_burst_data", 32'(oD), 32'(vecs[1].e));
        drain("bp_burst");

        // Reset in the middle of accumulation (count=1)
        sendOps(1'b1, 1'b1, vecs[2].w, vecs[2].d);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(vO), 32'd0);
        chk("midrst_data", 32'(oD), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready_w", 32'(rW), 32'd1);
        chk("midrst_ready_d", 32'(rD), 32'd1);
        k = 0;
        repeat (4) begin
            @(negedge clk);
            if (vO !== 1'b0) k++;
        end
        chk("midrst_no_stale", 32'(k), 32'd0);
        runVec(1);

        // Non-burst instance: readies stay low in DONE until IDLE
        @(negedge clk);
        vW2 = 1'b1; dW2 = vecs[0].w; vD2 = 1'b1; dD2 = vecs[0].d;
        @(posedge clk); #1;
        vW2 = 1'b0; vD2 = 1'b0;
        k = 0;
        while (!vO2 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("nb_latency", 32'(k), 32'd3);
        chk("nb_data", 32'(oD2), 32'(vecs[0].e));
        repeat (3) @(negedge clk);
        chk("nb_ready_w_done", 32'(rW2), 32'd0);
        chk("nb_ready_d_done", 32'(rD2), 32'd0);
        @(negedge clk);
        iR2 = 1'b1;
        @(posedge clk); #1;
        iR2 = 1'b0;
        chk("nb_valid_drop", 32'(vO2), 32'd0);
        @(negedge clk);
        chk("nb_ready_w_idle", 32'(rW2), 32'd1);
        chk("nb_ready_d_idle", 32'(rD2), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
